// File: rtl/line_buffer_3row_pkg.sv
// Shared image-pipeline constants: default geometry and line-buffer state encoding.
package line_buffer_3row_pkg;

  localparam int unsigned IMG_WIDTH_DEF = 512;
  localparam int unsigned PIX_W_DEF     = 8;

  // PRIME0: filling row 0, PRIME1: filling row 1, STREAM: emitting 3-row columns
  typedef enum logic [1:0] {
    ST_PRIME0 = 2'd0,
    ST_PRIME1 = 2'd1,
    ST_STREAM = 2'd2
  } lb_state_e;

  // State reached when a line completes without a start-of-frame
  function automatic lb_state_e next_on_wrap(input lb_state_e s);
    case (s)
      ST_PRIME0: next_on_wrap = ST_PRIME1;
      ST_PRIME1: next_on_wrap = ST_STREAM;
      default:   next_on_wrap = ST_STREAM;
    endcase
  endfunction

endpackage

// File: rtl/line_buffer_3row_line_ram.sv
// One image line of storage: synchronous write, asynchronous read, shared address.
// Ports: i_clk clock; i_we write enable; i_addr read/write address;
//        i_wdata write data; o_rdata combinational read data at i_addr.
module line_ram #(
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [WIDTH-1:0]  i_wdata,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents deliberately not reset; priming overwrites before use
  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_addr] <= i_wdata;
  end

  assign o_rdata = mem[i_addr];

endmodule

// File: rtl/line_buffer_3row.sv
// Three-row line buffer: turns a raster pixel stream into vertical 3-pixel columns
// {row r-2, row r-1, row r} once two full lines have been primed.
// Ports: i_clk, i_rst (sync, active-high); input stream i_pixel/i_pixel_valid/i_sof
//        with o_pixel_ack ready; output column o_pixel_1..3/o_pixel_valid with
//        downstream i_pixel_ack ready.
module line_buffer_3row
  import line_buffer_3row_pkg::*;
#(
  parameter int unsigned IMG_WIDTH = IMG_WIDTH_DEF,
  parameter int unsigned PIX_W     = PIX_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_sof,
  input  logic [PIX_W-1:0] i_pixel,
  input  logic             i_pixel_valid,
  output logic             o_pixel_ack,
  output logic [PIX_W-1:0] o_pixel_1,
  output logic [PIX_W-1:0] o_pixel_2,
  output logic [PIX_W-1:0] o_pixel_3,
  output logic             o_pixel_valid,
  input  logic             i_pixel_ack
);

  localparam int unsigned COL_W = $clog2(IMG_WIDTH);

  lb_state_e        state;
  logic [COL_W-1:0] col;
  logic [1:0]       row;

  logic             in_xfer;
  logic             out_xfer;
  logic [COL_W-1:0] col_eff;
  logic [COL_W-1:0] col_nxt;
  logic             col_wrap;
  logic [PIX_W-1:0] la_rd;
  logic [PIX_W-1:0] lb_rd;

  // One-deep output register: ready whenever it is empty or being drained
  assign o_pixel_ack = !o_pixel_valid || i_pixel_ack;
  assign in_xfer     = i_pixel_valid && o_pixel_ack && !i_rst;
  assign out_xfer    = o_pixel_valid && i_pixel_ack;

  // A start-of-frame pixel always lands in column 0
  assign col_eff  = i_sof ? '0 : col;
  assign col_wrap = (col_eff == COL_W'(IMG_WIDTH - 1));
  assign col_nxt  = col_wrap ? '0 : col_eff + COL_W'(1);

  // LA holds row r-1, LB holds row r-2; each transfer shifts the column down a line
  line_ram #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W), .ADDR_W(COL_W)) u_line_a (
    .i_clk   (i_clk),
    .i_we    (in_xfer),
    .i_addr  (col_eff),
    .i_wdata (i_pixel),
    .o_rdata (la_rd)
  );

  line_ram #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W), .ADDR_W(COL_W)) u_line_b (
    .i_clk   (i_clk),
    .i_we    (in_xfer),
    .i_addr  (col_eff),
    .i_wdata (la_rd),
    .o_rdata (lb_rd)
  );

  // Priming state machine, position counters and output column register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= ST_PRIME0;
      col           <= '0;
      row           <= 2'd0;
      o_pixel_valid <= 1'b0;
      o_pixel_1     <= '0;
      o_pixel_2     <= '0;
      o_pixel_3     <= '0;
    end else begin
      if (in_xfer) begin
        col <= col_nxt;
        if (i_sof) begin
          // Column 0 never wraps since a line is at least two pixels
          state <= ST_PRIME0;
          row   <= 2'd0;
        end else if (col_wrap) begin
          state <= next_on_wrap(state);
          if (row != 2'd2) row <= row + 2'd1;
        end
      end

      if (in_xfer && !i_sof && (state == ST_STREAM)) begin
        o_pixel_1     <= lb_rd;
        o_pixel_2     <= la_rd;
        o_pixel_3     <= i_pixel;
        o_pixel_valid <= 1'b1;
      end else if (out_xfer) begin
        o_pixel_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_line_buffer_3row.sv
// Self-checking bench for line_buffer_3row at IMG_WIDTH=4: directed priming,
// stall, start-of-frame and reset scenarios plus randomized multi-frame traffic,
// all checked by a scoreboard fed from a raster-position reference model.
module tb_line_buffer_3row;

  localparam int unsigned W  = 4;
  localparam int unsigned PW = 8;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_sof;
  logic [PW-1:0] i_pixel;
  logic          i_pixel_valid;
  logic          o_pixel_ack;
  logic [PW-1:0] o_pixel_1;
  logic [PW-1:0] o_pixel_2;
  logic [PW-1:0] o_pixel_3;
  logic          o_pixel_valid;
  logic          i_pixel_ack;

  line_buffer_3row #(.IMG_WIDTH(W), .PIX_W(PW)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_sof         (i_sof),
    .i_pixel       (i_pixel),
    .i_pixel_valid (i_pixel_valid),
    .o_pixel_ack   (o_pixel_ack),
    .o_pixel_1     (o_pixel_1),
    .o_pixel_2     (o_pixel_2),
    .o_pixel_3     (o_pixel_3),
    .o_pixel_valid (o_pixel_valid),
    .i_pixel_ack   (i_pixel_ack)
  );

  always #5 i_clk = ~i_clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          out_count = 0;
  int          in_count = 0;
  int          ack_mode = 0;     // 0: always ready, 1: random, 2: stalled
  logic [23:0] exp_q[$];
  logic [7:0]  hist [4096];      // pixels of the current frame by raster index
  int          frame_n = 0;
  logic [23:0] last_out = '0;
  logic        hold_pending = 1'b0;
  logic [23:0] hold_val = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model + scoreboard: sampled mid-cycle, ahead of the next rising edge
  always @(negedge i_clk) begin
    if (i_rst) begin
      exp_q.delete();
      frame_n      = 0;
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        check("hold_valid", 32'(o_pixel_valid), 32'd1);
        check("hold_data", 32'({o_pixel_1, o_pixel_2, o_pixel_3}), 32'(hold_val));
      end
      if (o_pixel_valid && i_pixel_ack) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_column: actual %0h required none at %0t",
                   {o_pixel_1, o_pixel_2, o_pixel_3}, $time);
        end else begin
          check("column", 32'({o_pixel_1, o_pixel_2, o_pixel_3}), 32'(exp_q.pop_front()));
        end
        out_count++;
        last_out = {o_pixel_1, o_pixel_2, o_pixel_3};
      end
      hold_pending = o_pixel_valid && !i_pixel_ack;
      hold_val     = {o_pixel_1, o_pixel_2, o_pixel_3};
      if (i_pixel_valid && o_pixel_ack) begin
        in_count++;
        if (i_sof) frame_n = 0;
        hist[frame_n] = i_pixel;
        // Column exists once two complete lines precede this pixel in the frame
        if (frame_n >= int'(2 * W))
          exp_q.push_back({hist[frame_n - int'(2 * W)], hist[frame_n - int'(W)], i_pixel});
        frame_n++;
      end
    end
  end

  // Downstream ready generator
  always @(posedge i_clk) begin
    #1;
    case (ack_mode)
      0:       i_pixel_ack = 1'b1;
      1:       i_pixel_ack = 1'($urandom_range(0, 1));
      default: i_pixel_ack = 1'b0;
    endcase
  end

  // Offer one pixel and return one step after the edge that accepted it
  task automatic send(input logic [7:0] p, input logic sof);
    int   waits;
    logic acc;
    waits = 0;
    i_pixel       = p;
    i_sof         = sof;
    i_pixel_valid = 1'b1;
    forever begin
      @(negedge i_clk);
      acc = o_pixel_ack;
      @(posedge i_clk);
      #1;
      if (acc) break;
      waits++;
      if (waits > 200) begin
        n_cmp++;
        n_bad++;
        $display("FAIL send_timeout: actual stalled required accept at %0t", $time);
        break;
      end
    end
    i_pixel_valid = 1'b0;
    i_sof         = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic do_reset();
    i_rst         = 1'b1;
    i_pixel_valid = 1'b0;
    i_sof         = 1'b0;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    check("rst_valid", 32'(o_pixel_valid), 32'd0);
    check("rst_data", 32'({o_pixel_1, o_pixel_2, o_pixel_3}), 32'd0);
    check("rst_ack", 32'(o_pixel_ack), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual running required finished at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int nin;
    int len;
    i_rst         = 1'b1;
    i_sof         = 1'b0;
    i_pixel       = '0;
    i_pixel_valid = 1'b0;
    i_pixel_ack   = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    do_reset();

    // Priming: two lines produce nothing, third line gives four columns
    base = out_count;
    for (int p = 1; p <= 8; p++) send(8'(p), 1'b0);
    idle(2);
    check("prime_no_output", 32'(out_count - base), 32'd0);
    send(8'd9, 1'b0);
    check("first_latency_valid", 32'(o_pixel_valid), 32'd1);
    check("first_column", 32'({o_pixel_1, o_pixel_2, o_pixel_3}), 32'h010509);
    for (int p = 10; p <= 12; p++) send(8'(p), 1'b0);
    idle(2);
    check("stream_count", 32'(out_count - base), 32'd4);
    check("last_column", 32'(last_out), 32'h04080c);

    // Start-of-frame restarts priming
    base = out_count;
    send(8'd13, 1'b1);
    for (int p = 14; p <= 20; p++) send(8'(p), 1'b0);
    idle(2);
    check("sof_no_output", 32'(out_count - base), 32'd0);
    send(8'd21, 1'b0);
    idle(2);
    check("sof_count", 32'(out_count - base), 32'd1);
    check("sof_column", 32'(last_out), 32'h0d1115);

    // Downstream stall freezes the column and blocks input
    do_reset();
    for (int p = 1; p <= 8; p++) send(8'(p), 1'b0);
    ack_mode    = 2;
    i_pixel_ack = 1'b0;
    send(8'd9, 1'b0);
    nin           = in_count;
    i_pixel       = 8'd10;
    i_pixel_valid = 1'b1;
    repeat (3) begin
      @(negedge i_clk);
      check("stall_ack", 32'(o_pixel_ack), 32'd0);
      check("stall_data", 32'({o_pixel_1, o_pixel_2, o_pixel_3}), 32'h010509);
    end
    @(posedge i_clk);
    #1;
    check("stall_no_input", 32'(in_count - nin), 32'd0);
    ack_mode    = 0;
    i_pixel_ack = 1'b1;
    for (int p = 10; p <= 12; p++) send(8'(p), 1'b0);
    idle(2);

    // Reset while a column is pending
    ack_mode    = 2;
    i_pixel_ack = 1'b0;
    send(8'd13, 1'b0);
    check("pre_reset_valid", 32'(o_pixel_valid), 32'd1);
    do_reset();
    ack_mode = 0;
    base     = out_count;
    for (int p = 1; p <= 8; p++) send(8'(p + 100), 1'b0);
    idle(2);
    check("post_reset_no_output", 32'(out_count - base), 32'd0);

    // Random gaps on both sides across three frames
    ack_mode = 1;
    for (int f = 0; f < 3; f++) begin
      len = int'(4 * W) + int'($urandom_range(0, 6));
      for (int k = 0; k < len; k++) begin
        idle(int'($urandom_range(0, 2)));
        send(8'($urandom), k == 0);
      end
    end
    idle(4);
    ack_mode = 0;
    idle(6);
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
